sobel_edge_stream: RTL and testbench

Streaming 3x3 Sobel edge detector directly downstream of the frame buffer. Consumes the buffer's raster-order 8-bit grayscale pixel stream with X/Y coordinates. Emits one edge magnitude per interior pixel, tagged with its centre coordinate, to the BMP output writer. The writer fills the one-pixel border with 0.

---
 rtl/sobel_pkg.sv | 42 ++++
 rtl/sobel_edge_stream_if.sv | 37 +++
 rtl/sobel_line_buffer.sv | 35 +++
 rtl/sobel_edge_stream.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sobel_edge_stream.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_pkg
//  Purpose  : Shared types, constants and arithmetic helpers for the
//             streaming Sobel edge detector.
//  Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int SOBEL_COORD_W = 11;

    // Signed gradient, range +/-1020
    typedef logic signed [10:0] grad_t;
    // Unsigned magnitude |Gx|+|Gy|, max 2040
    typedef logic [11:0] mag_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // 1-2-1 weighted sum of three pixels (max 1020)
    function automatic logic [9:0] weighted121(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Absolute value of a gradient, widened to magnitude width
    function automatic mag_t absGrad(input grad_t g);
        grad_t n;
        n = -g;
        return {1'b0, (g[10] ? n : g)};
    endfunction

    // Clamp a magnitude into the 8-bit output range
    function automatic logic [7:0] sat8(input mag_t m);
        return (m > mag_t'(255)) ? 8'hFF : m[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_edge_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_edge_stream_if
//  Purpose  : Pixel-in / edge-out stream bundle between the frame buffer,
//             the Sobel detector and the BMP writer.
//  Revision : 1.0 - initial release
// ============================================================================
interface sobel_edge_stream_if
    import sobel_pkg::*;
#(
    parameter int COORD_W = SOBEL_COORD_W
);
    logic               pix_valid;
    logic [7:0]         pix_in;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;

    logic               edge_valid;
    logic [7:0]         edge_out;
    logic [COORD_W-1:0] edge_x;
    logic [COORD_W-1:0] edge_y;
    logic               frame_done;
    logic               seq_err;

    // Pixel source side (frame buffer / testbench)
    modport master (
        output pix_valid, pix_in, pix_x, pix_y,
        input  edge_valid, edge_out, edge_x, edge_y, frame_done, seq_err
    );

    // Detector side
    modport slave (
        input  pix_valid, pix_in, pix_x, pix_y,
        output edge_valid, edge_out, edge_x, edge_y, frame_done, seq_err
    );
endinterface
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_line_buffer
//  Purpose  : One image row of pixel storage. Synchronous write, asynchronous
//             read, so a read of the address being written returns the old
//             byte (the previous row's pixel).
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int ADDR_W = $clog2(WIDTH)
) (
    input  wire logic              CAMERA_CLK,
    input  wire logic              i_wrEn,
    input  wire logic [ADDR_W-1:0] i_wrAddr,
    input  wire logic [7:0]        i_wrData,
    input  wire logic [ADDR_W-1:0] i_rdAddr,
    output logic      [7:0]        o_rdData
);

    logic [7:0] r_mem [WIDTH];

    // Store the incoming byte for this column
    always_ff @(posedge CAMERA_CLK) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule
`default_nettype wire

// File: rtl/sobel_edge_stream.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_edge_stream
//  Purpose  : Streaming 3x3 Sobel edge detector. Accepts raster-ordered
//             8-bit pixels with coordinates and emits |Gx|+|Gy| (saturated,
//             optionally binarized) per interior pixel, two cycles after the
//             pixel that completes its window.
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_edge_stream
    import sobel_pkg::*;
#(
    parameter int WIDTH   = 768,
    parameter int HEIGHT  = 512,
    parameter int COORD_W = SOBEL_COORD_W,
    parameter int THRESH  = 0
) (
    input wire logic          CAMERA_CLK,
    input wire logic          rst,
    sobel_edge_stream_if.slave stream
);

    localparam int                 c_ADDR_W = $clog2(WIDTH);
    localparam logic [COORD_W-1:0] c_ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] c_TWO    = COORD_W'(2);
    localparam logic [COORD_W-1:0] c_LAST_X = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] c_LAST_Y = COORD_W'(HEIGHT - 1);

    // ------------------------------------------------------------------
    // Raster-order tracking FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_nextState;
    logic [COORD_W-1:0] r_expX;
    logic [COORD_W-1:0] r_expY;
    logic               r_seqErr;
    logic               w_accept;
    logic               w_restart;
    logic               w_setErr;
    logic               w_isOrigin;
    logic               w_isExpected;
    logic               w_isLast;

    assign w_isOrigin   = (stream.pix_x == '0) && (stream.pix_y == '0);
    assign w_isExpected = (stream.pix_x == r_expX) && (stream.pix_y == r_expY);
    assign w_isLast     = (stream.pix_x == c_LAST_X) && (stream.pix_y == c_LAST_Y);

    // Decide whether the presented pixel is accepted and where the FSM goes
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_restart   = 1'b0;
        w_setErr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (stream.pix_valid && w_isOrigin) begin
                    w_accept    = 1'b1;
                    w_nextState = ACTIVE;
                end
            end
            ACTIVE: begin
                if (stream.pix_valid) begin
                    if (w_isOrigin) begin
                        // Early frame restart: not an error, but stale results die
                        w_accept  = 1'b1;
                        w_restart = 1'b1;
                    end else if (w_isExpected) begin
                        w_accept = 1'b1;
                        if (w_isLast) begin
                            w_nextState = IDLE;
                        end
                    end else begin
                        w_setErr    = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // FSM state, expected raster successor and sticky order-error flag
    always_ff @(posedge CAMERA_CLK) begin
        if (rst) begin
            r_state  <= IDLE;
            r_expX   <= '0;
            r_expY   <= '0;
            r_seqErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_setErr) begin
                r_seqErr <= 1'b1;
            end
            if (w_accept) begin
                if (stream.pix_x == c_LAST_X) begin
                    r_expX <= '0;
                    r_expY <= stream.pix_y + c_ONE;
                end else begin
                    r_expX <= stream.pix_x + c_ONE;
                    r_expY <= stream.pix_y;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers (row y-1 feeds row y-2) and 3x3 window
    // ------------------------------------------------------------------
    logic [c_ADDR_W-1:0] w_addr;
    logic [7:0]          w_rowM1;
    logic [7:0]          w_rowM2;

    assign w_addr = stream.pix_x[c_ADDR_W-1:0];

    sobel_line_buffer #(
        .WIDTH (WIDTH),
        .ADDR_W(c_ADDR_W)
    ) u_lineBufM1 (
        .CAMERA_CLK(CAMERA_CLK),
        .i_wrEn    (w_accept),
        .i_wrAddr  (w_addr),
        .i_wrData  (stream.pix_in),
        .i_rdAddr  (w_addr),
        .o_rdData  (w_rowM1)
    );

    sobel_line_buffer #(
        .WIDTH (WIDTH),
        .ADDR_W(c_ADDR_W)
    ) u_lineBufM2 (
        .CAMERA_CLK(CAMERA_CLK),
        .i_wrEn    (w_accept),
        .i_wrAddr  (w_addr),
        .i_wrData  (w_rowM1),
        .i_rdAddr  (w_addr),
        .o_rdData  (w_rowM2)
    );

    // Window indexed [row][col]; row 0 = y-2, col 0 = x-2
    logic [2:0][2:0][7:0] r_win;
    logic [2:0][2:0][7:0] w_win;

    // Window as it will be after shifting in the current column
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_win[r][0] = r_win[r][1];
            w_win[r][1] = r_win[r][2];
        end
        w_win[0][2] = w_rowM2;
        w_win[1][2] = w_rowM1;
        w_win[2][2] = stream.pix_in;
    end

    // Shift the window on every accepted pixel; stale columns are overwritten
    // before any window that uses them completes
    always_ff @(posedge CAMERA_CLK) begin
        if (w_accept) begin
            r_win <= w_win;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: gradients from the post-shift window
    // ------------------------------------------------------------------
    logic [9:0] w_colR;
    logic [9:0] w_colL;
    logic [9:0] w_rowB;
    logic [9:0] w_rowT;
    grad_t      w_gradX;
    grad_t      w_gradY;
    logic       w_complete;

    assign w_colR  = weighted121(w_win[0][2], w_win[1][2], w_win[2][2]);
    assign w_colL  = weighted121(w_win[0][0], w_win[1][0], w_win[2][0]);
    assign w_rowB  = weighted121(w_win[2][0], w_win[2][1], w_win[2][2]);
    assign w_rowT  = weighted121(w_win[0][0], w_win[0][1], w_win[0][2]);
    assign w_gradX = $signed({1'b0, w_colR}) - $signed({1'b0, w_colL});
    assign w_gradY = $signed({1'b0, w_rowB}) - $signed({1'b0, w_rowT});

    assign w_complete = w_accept && (stream.pix_x >= c_TWO) && (stream.pix_y >= c_TWO);

    logic               r_s1Valid;
    logic               r_s1Last;
    grad_t              r_s1GradX;
    grad_t              r_s1GradY;
    logic [COORD_W-1:0] r_s1X;
    logic [COORD_W-1:0] r_s1Y;

    // Register gradients and centre coordinate of a completed window
    always_ff @(posedge CAMERA_CLK) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
        end else begin
            r_s1Valid <= w_complete;
        end
        if (w_complete) begin
            r_s1GradX <= w_gradX;
            r_s1GradY <= w_gradY;
            r_s1X     <= stream.pix_x - c_ONE;
            r_s1Y     <= stream.pix_y - c_ONE;
            r_s1Last  <= w_isLast;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: magnitude, saturation, optional threshold
    // ------------------------------------------------------------------
    mag_t       w_mag;
    logic [7:0] w_sat;
    logic [7:0] w_edgeVal;

    assign w_mag = absGrad(r_s1GradX) + absGrad(r_s1GradY);
    assign w_sat = sat8(w_mag);

    generate
        if (THRESH == 0) begin : g_raw
            assign w_edgeVal = w_sat;
        end else begin : g_binarize
            assign w_edgeVal = (int'(w_sat) >= THRESH) ? 8'hFF : 8'h00;
        end
    endgenerate

    logic               r_edgeValid;
    logic               r_frameDone;
    logic [7:0]         r_edgeOut;
    logic [COORD_W-1:0] r_edgeX;
    logic [COORD_W-1:0] r_edgeY;
    logic               w_emit;

    // A frame restart kills the result still sitting in stage 1
    assign w_emit = r_s1Valid && !w_restart;

    // Output register stage
    always_ff @(posedge CAMERA_CLK) begin
        if (rst) begin
            r_edgeValid <= 1'b0;
            r_frameDone <= 1'b0;
            r_edgeOut   <= '0;
            r_edgeX     <= '0;
            r_edgeY     <= '0;
        end else begin
            r_edgeValid <= w_emit;
            r_frameDone <= w_emit && r_s1Last;
            if (w_emit) begin
                r_edgeOut <= w_edgeVal;
                r_edgeX   <= r_s1X;
                r_edgeY   <= r_s1Y;
            end
        end
    end

    assign stream.edge_valid = r_edgeValid;
    assign stream.edge_out   = r_edgeOut;
    assign stream.edge_x     = r_edgeX;
    assign stream.edge_y     = r_edgeY;
    assign stream.frame_done = r_frameDone;
    assign stream.seq_err    = r_seqErr;

endmodule
`default_nettype wire

// File: tb/tb_sobel_edge_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_edge_stream
//  Purpose  : Self-checking bench for sobel_edge_stream on an 8x6 image.
//             Two instances (raw and THRESH=30) share one pixel stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_edge_stream;
    import sobel_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 11;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          pixValid = 1'b0;
    logic [7:0]    pixIn    = '0;
    logic [CW-1:0] pixX     = '0;
    logic [CW-1:0] pixY     = '0;

    always #5 clk = ~clk;

    sobel_edge_stream_if #(.COORD_W(CW)) busA ();
    sobel_edge_stream_if #(.COORD_W(CW)) busB ();

    assign busA.pix_valid = pixValid;
    assign busA.pix_in    = pixIn;
    assign busA.pix_x     = pixX;
    assign busA.pix_y     = pixY;
    assign busB.pix_valid = pixValid;
    assign busB.pix_in    = pixIn;
    assign busB.pix_x     = pixX;
    assign busB.pix_y     = pixY;

    sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .THRESH(0)) dutA (
        .CAMERA_CLK(clk), .rst(rst), .stream(busA.slave)
    );
    sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW), .THRESH(30)) dutB (
        .CAMERA_CLK(clk), .rst(rst), .stream(busB.slave)
    );

    typedef struct {
        int x;
        int y;
        int valA;
        int valB;
        bit last;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t mon;
    int   img [H][W];
    int   cyc    = 0;
    int   total  = 0;
    int   bad    = 0;
    int   outCnt = 0;
    int   fdCnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference Sobel magnitude straight from the image definition
    function automatic int sobelAt(input int cx, input int cy);
        int gx, gy, m;
        gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
        gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    // Scoreboard monitor: every output is popped against the expected queue
    always @(negedge clk) begin
        if (busA.edge_valid || busB.edge_valid) begin
            outCnt++;
            if (busA.frame_done) fdCnt++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output cycle %0d: got (%0d,%0d) A=%0d B=%0d, expected no output",
                         cyc, busA.edge_x, busA.edge_y, busA.edge_out, busB.edge_out);
            end else begin
                mon = q.pop_front();
                if ({busA.edge_valid, busB.edge_valid, busA.edge_x, busA.edge_y, busB.edge_x, busB.edge_y,
                     busA.edge_out, busB.edge_out, busA.frame_done, busB.frame_done} !==
                    {2'b11, CW'(mon.x), CW'(mon.y), CW'(mon.x), CW'(mon.y),
                     8'(mon.valA), 8'(mon.valB), mon.last, mon.last} || cyc != mon.due) begin
                    bad++;
                    $display("FAIL edge_output got v=%b%b (%0d,%0d) A=%0d B=%0d fd=%b%b cyc=%0d, expected (%0d,%0d) A=%0d B=%0d fd=%b cyc=%0d",
                             busA.edge_valid, busB.edge_valid, busA.edge_x, busA.edge_y, busA.edge_out,
                             busB.edge_out, busA.frame_done, busB.frame_done, cyc,
                             mon.x, mon.y, mon.valA, mon.valB, mon.last, mon.due);
                end
            end
        end else begin
            if (q.size() > 0 && q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_output at cycle %0d: got none, expected (%0d,%0d) A=%0d due cycle %0d",
                         cyc, q[0].x, q[0].y, q[0].valA, q[0].due);
                q.delete(0);
            end
            if (busA.frame_done || busB.frame_done) begin
                total++;
                bad++;
                $display("FAIL stray_frame_done at cycle %0d: got %b%b without edge_valid, expected 0",
                         cyc, busA.frame_done, busB.frame_done);
            end
        end
    end

    task automatic sendPix(input int x, input int y, input bit push, input bit restart);
        exp_t e;
        @(negedge clk);
        if (restart) begin
            while (q.size() > 0 && q[q.size()-1].due > cyc) q.delete(q.size()-1);
        end
        pixValid = 1'b1;
        pixX     = CW'(x);
        pixY     = CW'(y);
        pixIn    = 8'(img[y][x]);
        if (push && x >= 2 && y >= 2) begin
            e.x    = x - 1;
            e.y    = y - 1;
            e.valA = sobelAt(x - 1, y - 1);
            e.valB = (e.valA >= 30) ? 255 : 0;
            e.last = (x == W - 1) && (y == H - 1);
            e.due  = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pixValid = 1'b0;
    endtask

    task automatic sendFrame(input bit gap, input bit restart);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                sendPix(x, y, 1'b1, restart && x == 0 && y == 0);
                if (gap) idle();
            end
        end
        idle();
        repeat (6) @(negedge clk);
    endtask

    task automatic fillFlat(input int v);
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
    endtask

    task automatic fillVStep();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x < 4) ? 0 : 100;
    endtask

    task automatic fillHStep();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (y < 3) ? 0 : 10;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pixValid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busA.edge_valid !== 1'b0) begin bad++; $display("FAIL reset_edge_valid got %b expected 0", busA.edge_valid); end
        total++;
        if (busA.edge_out !== 8'd0) begin bad++; $display("FAIL reset_edge_out got %0d expected 0", busA.edge_out); end
        total++;
        if (busA.edge_x !== '0 || busA.edge_y !== '0) begin
            bad++; $display("FAIL reset_edge_xy got (%0d,%0d) expected (0,0)", busA.edge_x, busA.edge_y);
        end
        total++;
        if (busA.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got %b expected 0", busA.frame_done); end
        total++;
        if (busA.seq_err !== 1'b0 || busB.seq_err !== 1'b0) begin
            bad++; $display("FAIL reset_seq_err got %b%b expected 00", busA.seq_err, busB.seq_err);
        end
        total++;
        if ({busB.edge_valid, busB.edge_out, busB.frame_done} !== 10'd0) begin
            bad++; $display("FAIL reset_dutB got v=%b out=%0d fd=%b expected all 0",
                            busB.edge_valid, busB.edge_out, busB.frame_done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkFrameCounts(input string name, input int o0, input int f0,
                                    input int expOut, input int expFd);
        total++;
        if (outCnt - o0 !== expOut) begin
            bad++; $display("FAIL %s_count got %0d outputs expected %0d", name, outCnt - o0, expOut);
        end
        total++;
        if (fdCnt - f0 !== expFd) begin
            bad++; $display("FAIL %s_frame_done got %0d pulses expected %0d", name, fdCnt - f0, expFd);
        end
    endtask

    task automatic test_flat();
        int o0 = outCnt, f0 = fdCnt;
        fillFlat(50);
        sendFrame(1'b0, 1'b0);
        checkFrameCounts("flat", o0, f0, 24, 1);
    endtask

    task automatic test_vertical_step();
        int o0 = outCnt, f0 = fdCnt;
        fillVStep();
        sendFrame(1'b0, 1'b0);
        checkFrameCounts("vstep", o0, f0, 24, 1);
    endtask

    task automatic test_horizontal_step();
        int o0 = outCnt, f0 = fdCnt;
        fillHStep();
        sendFrame(1'b0, 1'b0);
        checkFrameCounts("hstep", o0, f0, 24, 1);
    endtask

    task automatic test_gaps();
        int o0 = outCnt, f0 = fdCnt;
        fillVStep();
        sendFrame(1'b1, 1'b0);
        checkFrameCounts("gaps", o0, f0, 24, 1);
    endtask

    task automatic test_restart();
        int o0 = outCnt, f0 = fdCnt;
        fillHStep();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y < 3 || x <= 4) sendPix(x, y, 1'b1, 1'b0);
            end
        end
        // Row 2 gives 6 results, row 3 gives 3 of which the last is discarded
        sendFrame(1'b0, 1'b1);
        checkFrameCounts("restart", o0, f0, 8 + 24, 1);
        total++;
        if (busA.seq_err !== 1'b0) begin bad++; $display("FAIL restart_seq_err got %b expected 0", busA.seq_err); end
    endtask

    task automatic test_seq_err();
        int o0 = outCnt, f0 = fdCnt;
        fillVStep();
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y < 2 || x <= 3) sendPix(x, y, 1'b1, 1'b0);
            end
        end
        sendPix(5, 2, 1'b0, 1'b0);
        sendPix(6, 2, 1'b0, 1'b0);
        sendPix(7, 2, 1'b0, 1'b0);
        sendPix(0, 3, 1'b0, 1'b0);
        idle();
        repeat (6) @(negedge clk);
        total++;
        if (busA.seq_err !== 1'b1 || busB.seq_err !== 1'b1) begin
            bad++; $display("FAIL seq_err_set got %b%b expected 11", busA.seq_err, busB.seq_err);
        end
        checkFrameCounts("seq_err_abort", o0, f0, 2, 0);
        o0 = outCnt;
        f0 = fdCnt;
        fillHStep();
        sendFrame(1'b0, 1'b0);
        checkFrameCounts("seq_err_recover", o0, f0, 24, 1);
        total++;
        if (busA.seq_err !== 1'b1) begin bad++; $display("FAIL seq_err_sticky got %b expected 1", busA.seq_err); end
    endtask

    task automatic test_reset_mid_frame();
        int o0 = outCnt, f0 = fdCnt;
        fillVStep();
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y < 3 || x <= 3) sendPix(x, y, 1'b1, 1'b0);
            end
        end
        @(negedge clk);
        pixValid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (busA.seq_err !== 1'b0 || busB.seq_err !== 1'b0) begin
            bad++; $display("FAIL reset_clears_seq_err got %b%b expected 00", busA.seq_err, busB.seq_err);
        end
        total++;
        if (fdCnt - f0 !== 0) begin
            bad++; $display("FAIL aborted_frame_done got %0d pulses expected 0", fdCnt - f0);
        end
        o0 = outCnt;
        f0 = fdCnt;
        fillFlat(50);
        sendFrame(1'b0, 1'b0);
        checkFrameCounts("after_reset", o0, f0, 24, 1);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vertical_step();
        test_horizontal_step();
        test_gaps();
        test_restart();
        test_seq_err();
        test_reset_mid_frame();
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
